// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle of the VGA timing generator: colour/mode inputs, coordinates, syncs and colour outputs.
// slave = the generator, master = the pixel source / display consumer.
interface vga_timing_gen_if #(
    parameter int COLOR_W = 4,
    parameter int X_W     = 10,
    parameter int Y_W     = 10
);
    logic [3*COLOR_W-1:0] rgb_in;
    logic [1:0]           mode;
    logic [X_W-1:0]       x;
    logic [Y_W-1:0]       y;
    logic                 pix_en;
    logic                 hs;
    logic                 vs;
    logic [COLOR_W-1:0]   r;
    logic [COLOR_W-1:0]   g;
    logic [COLOR_W-1:0]   b;
    logic                 de;
    logic                 frame_start;
    logic                 line_start;

    modport slave (
        input  rgb_in, mode,
        output x, y, pix_en, hs, vs, r, g, b, de, frame_start, line_start
    );

    modport master (
        output rgb_in, mode,
        input  x, y, pix_en, hs, vs, r, g, b, de, frame_start, line_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, x/y counters, registered syncs/DE/colour/start pulses.
// Macro VGA_TEST_PATTERN_EN adds colour bars (mode 2) and a 32x32 checkerboard (mode 3).
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 4,
    parameter int COLOR_W  = 4,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    vga_timing_gen_if.slave bus
);
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int XW    = $clog2(H_TOT);
    localparam int YW    = $clog2(V_TOT);
    // One extra bit so a sync end equal to the total cannot alias to zero.
    localparam int XC    = XW + 1;
    localparam int YC    = YW + 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [XW-1:0]    X_LAST   = XW'(H_TOT - 1);
    localparam logic [YW-1:0]    Y_LAST   = YW'(V_TOT - 1);
    localparam logic [XC-1:0]    H_ACT_C  = XC'(H_ACTIVE);
    localparam logic [XC-1:0]    HS_BEG_C = XC'(H_ACTIVE + H_FP);
    localparam logic [XC-1:0]    HS_END_C = XC'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YC-1:0]    V_ACT_C  = YC'(V_ACTIVE);
    localparam logic [YC-1:0]    VS_BEG_C = YC'(V_ACTIVE + V_FP);
    localparam logic [YC-1:0]    VS_END_C = YC'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0]   div_q, div_d;
    logic [XW-1:0]      x_q, x_d;
    logic [YW-1:0]      y_q, y_d;
    logic               hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d, ls_q, ls_d;
    logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic               pix_en;
    logic [XC-1:0]      xe;
    logic [YC-1:0]      ye;

    assign pix_en = (div_q == DIV_LAST);
    assign xe     = {1'b0, x_q};
    assign ye     = {1'b0, y_q};

`ifdef VGA_TEST_PATTERN_EN
    localparam int            BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
    localparam logic [XW-1:0] BAR_C = XW'(BAR_W);
    logic [2:0] bar_idx;
    logic       chk;
    assign bar_idx = 3'(x_q / BAR_C);
    assign chk     = 1'((32'(x_q) >> 5) ^ (32'(y_q) >> 5));
`endif

    always_comb begin
        div_d = pix_en ? '0 : div_q + 1'b1;
        x_d   = x_q;
        y_d   = y_q;
        if (pix_en) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // Everything below is computed from the current x/y and captured on pix_en.
    always_comb begin
        de_d = (xe < H_ACT_C) && (ye < V_ACT_C);
        hs_d = ((xe >= HS_BEG_C) && (xe < HS_END_C)) ? HS_POL : ~HS_POL;
        vs_d = ((ye >= VS_BEG_C) && (ye < VS_END_C)) ? VS_POL : ~VS_POL;
        fs_d = (x_q == '0) && (y_q == '0);
        ls_d = (x_q == '0);
        {r_d, g_d, b_d} = bus.rgb_in;
        case (bus.mode)
            2'd1: {r_d, g_d, b_d} = '1;
`ifdef VGA_TEST_PATTERN_EN
            2'd2: begin
                r_d = {COLOR_W{bar_idx[2]}};
                g_d = {COLOR_W{bar_idx[1]}};
                b_d = {COLOR_W{bar_idx[0]}};
            end
            2'd3: {r_d, g_d, b_d} = {3*COLOR_W{chk}};
`endif
            default: ;
        endcase
        if (!de_d) {r_d, g_d, b_d} = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            de_q  <= 1'b0;
            fs_q  <= 1'b0;
            ls_q  <= 1'b0;
            r_q   <= '0;
            g_q   <= '0;
            b_q   <= '0;
        end else begin
            div_q <= div_d;
            x_q   <= x_d;
            y_q   <= y_d;
            if (pix_en) begin
                hs_q <= hs_d;
                vs_q <= vs_d;
                de_q <= de_d;
                fs_q <= fs_d;
                ls_q <= ls_d;
                r_q  <= r_d;
                g_q  <= g_d;
                b_q  <= b_d;
            end
        end
    end

    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.pix_en      = pix_en;
    assign bus.hs          = hs_q;
    assign bus.vs          = vs_q;
    assign bus.de          = de_q;
    assign bus.frame_start = fs_q;
    assign bus.line_start  = ls_q;
    assign bus.r           = r_q;
    assign bus.g           = g_q;
    assign bus.b           = b_q;
endmodule
